// File: rtl/given_cache_control.sv
// given_cache_control: control FSM for the direct-mapped, 8-set, 256-bit-line
// cache. Sequences the tag/valid/dirty array loads and the data-array write
// mode, runs the CPU and physical-memory handshakes for dirty writeback and
// line fill, and keeps hit/miss/writeback performance counters.
`timescale 1ns/1ps

module given_cache_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  // CPU side
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  // cache datapath
  input  logic             hit,
  input  logic             dirty_out,
  output logic             tag_load,
  output logic             valid_load,
  output logic             dirty_load,
  output logic             dirty_in,
  output logic [1:0]       writing,
  // physical memory / arbiter side
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  // performance counters
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    FILL,
    RECHECK
  } state_t;

  // Data-array write modes.
  localparam logic [1:0] WR_FILL = 2'b00;  // whole line from pmem_rdata
  localparam logic [1:0] WR_CPU  = 2'b01;  // byte-enabled CPU merge
  localparam logic [1:0] WR_HOLD = 2'b10;  // no data-array write

  state_t state;
  state_t next_state;

  // Request kind captured when leaving IDLE, so a CPU that drops its request
  // early still gets the transaction it started (read or write) completed.
  logic req_write;

  // State register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Latch request type on acceptance; a simultaneous read+write is a write.
  always_ff @(posedge clk) begin
    if (!rst_n)                                         req_write <= 1'b0;
    else if (state == IDLE && (mem_read || mem_write))  req_write <= mem_write;
  end

  // Performance counters; they wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (state == COMPARE && hit)        hit_count  <= hit_count  + CNT_W'(1);
      if (state == COMPARE && !hit)       miss_count <= miss_count + CNT_W'(1);
      if (state == WRITEBACK && pmem_resp) wb_count  <= wb_count   + CNT_W'(1);
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // next_state unassigned, which would infer a latch.
    next_state = state;
    unique case (state)
      IDLE:      if (mem_read || mem_write) next_state = COMPARE;
      COMPARE:   if (hit)            next_state = IDLE;
                 else if (dirty_out) next_state = WRITEBACK;
                 else                next_state = FILL;
      WRITEBACK: if (pmem_resp) next_state = FILL;
      FILL:      if (pmem_resp) next_state = RECHECK;
      // A miss after a fill means memory answered with the wrong line;
      // refetch rather than hand the CPU stale data.
      RECHECK:   next_state = hit ? IDLE : FILL;
      default:   next_state = IDLE;
    endcase
  end

  // Output decode from state plus datapath/pmem inputs.
  always_comb begin
    mem_resp   = 1'b0;
    tag_load   = 1'b0;
    valid_load = 1'b0;
    dirty_load = 1'b0;
    dirty_in   = 1'b0;
    writing    = WR_HOLD;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    unique case (state)
      IDLE: ;
      COMPARE, RECHECK: begin
        if (hit) begin
          mem_resp = 1'b1;
          if (req_write) begin
            writing    = WR_CPU;
            dirty_load = 1'b1;
            dirty_in   = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        // Victim address is presented while dirty_out stays high; clearing
        // dirty on the response flips pmem_address to the request address.
        pmem_write = 1'b1;
        if (pmem_resp) begin
          dirty_load = 1'b1;
          dirty_in   = 1'b0;
        end
      end
      FILL: begin
        // Hold the data array until the line actually arrives.
        pmem_read = 1'b1;
        if (pmem_resp) begin
          writing    = WR_FILL;
          tag_load   = 1'b1;
          valid_load = 1'b1;
          dirty_load = 1'b1;
          dirty_in   = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_given_cache_control.sv
// tb_given_cache_control: drives CPU requests against a behavioural model of
// the tag/valid/dirty arrays and a delay-programmable physical memory, and
// scoreboards latency, write-path strobes and counters per request.
`timescale 1ns/1ps

module tb_given_cache_control;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mem_read, mem_write, mem_resp;
  logic             hit, dirty_out;
  logic             tag_load, valid_load, dirty_load, dirty_in;
  logic [1:0]       writing;
  logic             pmem_read, pmem_write, pmem_resp;
  logic [CNT_W-1:0] hit_count, miss_count, wb_count;

  given_cache_control #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_resp   (mem_resp),
    .hit        (hit),
    .dirty_out  (dirty_out),
    .tag_load   (tag_load),
    .valid_load (valid_load),
    .dirty_load (dirty_load),
    .dirty_in   (dirty_in),
    .writing    (writing),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_resp  (pmem_resp),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .wb_count   (wb_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Datapath model: address = {tag[31:8], index[7:5], offset[4:0]}.
  logic [31:0] addr = 32'h0;
  logic [23:0] tag_m   [8] = '{default: 24'h0};
  logic        valid_m [8] = '{default: 1'b0};
  logic        dirty_m [8] = '{default: 1'b0};

  assign hit       = valid_m[addr[7:5]] && (tag_m[addr[7:5]] == addr[31:8]);
  assign dirty_out = dirty_m[addr[7:5]];

  always @(posedge clk) begin
    if (tag_load)   tag_m[addr[7:5]]   <= addr[31:8];
    if (valid_load) valid_m[addr[7:5]] <= 1'b1;
    if (dirty_load) dirty_m[addr[7:5]] <= dirty_in;
  end

  // Physical memory: answers a request after wb_delay/fill_delay idle cycles
  // with a one-cycle pmem_resp. Updated 1 time unit after each rising edge.
  int wb_delay   = 0;
  int fill_delay = 0;
  int wait_cnt   = 0;

  initial begin
    pmem_resp = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        wait_cnt  = 0;
      end
      if (pmem_read || pmem_write) begin
        if (wait_cnt >= (pmem_write ? wb_delay : fill_delay)) pmem_resp = 1'b1;
        else                                                   wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard entry: expected latency (edges from request to the edge that
  // sees mem_resp), expected write path, and counters after completion.
  typedef struct {
    int          lat;
    bit          wr;
    logic [31:0] h;
    logic [31:0] m;
    logic [31:0] w;
  } exp_t;

  exp_t sb[$];
  logic [31:0] exp_hit = 0, exp_miss = 0, exp_wb = 0;

  // Issue one CPU request and follow it to completion.
  task automatic do_request(input logic [31:0] a, input bit rd, input bit wr,
                            input int wb_d, input int fill_d, input string name);
    exp_t e;
    exp_t got;
    int   n;
    bit   done;
    logic [2:0] idx;
    idx        = a[7:5];
    wb_delay   = wb_d;
    fill_delay = fill_d;
    e.wr = wr;
    if (valid_m[idx] && tag_m[idx] == a[31:8]) begin
      exp_hit++;
      e.lat = 2;
    end else begin
      exp_miss++;
      if (dirty_m[idx]) begin
        exp_wb++;
        e.lat = 3 + (wb_d + 1) + (fill_d + 1);
      end else begin
        e.lat = 3 + (fill_d + 1);
      end
    end
    e.h = exp_hit; e.m = exp_miss; e.w = exp_wb;
    sb.push_back(e);

    addr = a; mem_read = rd; mem_write = wr;
    n = 0; done = 1'b0;
    while (!done && n < 200) begin
      @(posedge clk);
      #3;
      n++;
      total++;
      if (pmem_read && pmem_write) begin
        bad++;
        $display("FAIL %s pmem_exclusive: read=%b write=%b, need not both", name, pmem_read, pmem_write);
      end
      if (pmem_read && !pmem_resp) begin
        total++;
        if ({writing, tag_load, valid_load} !== 4'b10_00) begin
          bad++;
          $display("FAIL %s fill_wait: writing/tag/valid=%b need 1000", name, {writing, tag_load, valid_load});
        end
      end
      if (pmem_read && pmem_resp) begin
        total++;
        if ({writing, tag_load, valid_load, dirty_load, dirty_in} !== 6'b00_1110) begin
          bad++;
          $display("FAIL %s fill_resp: writing/tag/valid/dload/din=%b need 001110", name,
                   {writing, tag_load, valid_load, dirty_load, dirty_in});
        end
      end
      if (pmem_write && pmem_resp) begin
        total++;
        if ({writing, dirty_load, dirty_in} !== 4'b10_10) begin
          bad++;
          $display("FAIL %s wb_resp: writing/dload/din=%b need 1010", name, {writing, dirty_load, dirty_in});
        end
      end
      if (mem_resp) begin
        done = 1'b1;
        got  = sb.pop_front();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        total++;
        if (n + 1 !== got.lat) begin
          bad++;
          $display("FAIL %s latency: got %0d need %0d", name, n + 1, got.lat);
        end
        total++;
        if ({writing, dirty_load, dirty_in} !== (got.wr ? 4'b01_11 : 4'b10_00)) begin
          bad++;
          $display("FAIL %s resp_path: writing/dload/din=%b need %b", name,
                   {writing, dirty_load, dirty_in}, (got.wr ? 4'b01_11 : 4'b10_00));
        end
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s timeout: no mem_resp in 200 cycles", name);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      @(posedge clk);
      #3;
      total++;
      if (mem_resp !== 1'b0) begin
        bad++;
        $display("FAIL %s resp_width: mem_resp=%b one cycle later, need 0", name, mem_resp);
      end
      total++;
      if ({hit_count, miss_count, wb_count} !== {got.h, got.m, got.w}) begin
        bad++;
        $display("FAIL %s counters: h/m/w=%0d/%0d/%0d need %0d/%0d/%0d", name,
                 hit_count, miss_count, wb_count, got.h, got.m, got.w);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    total++;
    if ({mem_resp, pmem_read, pmem_write, tag_load, valid_load, dirty_load, dirty_in, writing} !== 9'b0000000_10) begin
      bad++;
      $display("FAIL reset_outputs: got %b need 000000010",
               {mem_resp, pmem_read, pmem_write, tag_load, valid_load, dirty_load, dirty_in, writing});
    end
    total++;
    if ({hit_count, miss_count, wb_count} !== '0) begin
      bad++;
      $display("FAIL reset_counters: h/m/w=%0d/%0d/%0d need 0/0/0", hit_count, miss_count, wb_count);
    end
    rst_n = 1'b1;
    exp_hit = 0; exp_miss = 0; exp_wb = 0;
  endtask

  task automatic test_cold_read();
    do_request(32'h0000_0040, 1'b1, 1'b0, 0, 0, "cold_read");
    do_request(32'h0000_0040, 1'b1, 1'b0, 0, 0, "read_hit");
  endtask

  task automatic test_write_hit();
    do_request(32'h0000_0044, 1'b0, 1'b1, 0, 0, "write_hit");
  endtask

  task automatic test_dirty_evict();
    do_request(32'h0000_1040, 1'b1, 1'b0, 2, 1, "dirty_evict");
  endtask

  task automatic test_slow_fill();
    do_request(32'h0000_2080, 1'b1, 1'b0, 0, 10, "slow_fill");
  endtask

  task automatic test_reset_in_writeback();
    do_request(32'h0000_1044, 1'b0, 1'b1, 0, 0, "dirty_again");
    wb_delay = 20;
    addr = 32'h0000_0040; mem_read = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    total++;
    if (pmem_write !== 1'b1) begin
      bad++;
      $display("FAIL rst_wb_entry: pmem_write=%b need 1", pmem_write);
    end
    rst_n = 1'b0; mem_read = 1'b0;
    @(posedge clk);
    #3;
    total++;
    if ({pmem_write, pmem_read, mem_resp} !== 3'b000) begin
      bad++;
      $display("FAIL rst_wb_abort: pmem_write/read/resp=%b need 000", {pmem_write, pmem_read, mem_resp});
    end
    total++;
    if ({hit_count, miss_count, wb_count} !== '0) begin
      bad++;
      $display("FAIL rst_wb_counters: h/m/w=%0d/%0d/%0d need 0/0/0", hit_count, miss_count, wb_count);
    end
    rst_n = 1'b1;
    exp_hit = 0; exp_miss = 0; exp_wb = 0;
    @(posedge clk);
    #3;
    do_request(32'h0000_0040, 1'b1, 1'b0, 1, 2, "after_reset_miss");
  endtask

  task automatic test_read_write_both();
    do_request(32'h0000_0048, 1'b1, 1'b1, 0, 0, "rd_wr_both");
    total++;
    if (dirty_m[2] !== 1'b1) begin
      bad++;
      $display("FAIL rd_wr_both_dirty: dirty[2]=%b need 1", dirty_m[2]);
    end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_hit();
    test_dirty_evict();
    test_slow_fill();
    test_reset_in_writeback();
    test_read_write_both();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/given_cache_control.md
Name: given_cache_control

Overview:
- Control FSM for the direct-mapped, 8-set, 256-bit-line given cache datapath.
- Sequences tag/valid/dirty array loads and the data-array write mode (`writing`).
- Runs the CPU-side handshake and the physical-memory handshake for dirty writeback and line fill.
- Also keeps hit, miss and writeback performance counters. It sits between the CPU memory port, the cache datapath and the physical-memory/arbiter port.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- mem_read  input  1  CPU read request; held high until mem_resp
- mem_write  input  1  CPU write request; held high until mem_resp
- mem_resp  output  1  one-cycle completion pulse to CPU
- hit  input  1  datapath tag match AND valid for current mem_address index
- dirty_out  input  1  dirty bit of indexed set
- tag_load  output  1  load address tag into tag array
- valid_load  output  1  set valid bit of indexed set
- dirty_load  output  1  write dirty_in into dirty array
- dirty_in  output  1  dirty value to store
- writing  output  2  00 = fill line from pmem_rdata (full mask); 01 = CPU write with mem_byte_enable; 10 = hold, no data-array write
- pmem_read  output  1  line read request to physical memory
- pmem_write  output  1  line write request to physical memory
- pmem_resp  input  1  one-cycle completion pulse from physical memory
- hit_count  output  CNT_W  number of requests completed as hits on first compare
- miss_count  output  CNT_W  number of requests that missed on first compare
- wb_count  output  CNT_W  number of dirty writebacks performed

Behaviour:
- States: IDLE, COMPARE, WRITEBACK, FILL, RECHECK. Outputs are decoded combinationally from the state plus inputs.
- Default outputs in every state: all strobes 0, dirty_in = 0, writing = 10.
- Reset (rst_n = 0 at an edge): state goes to IDLE and all counters go to 0. The outputs are therefore mem_resp = 0, pmem_read = 0, pmem_write = 0, all loads = 0, writing = 10 from the following cycle.
- Reset mid-writeback or mid-fill abandons the pmem transaction; the pmem request drops in the cycle after reset.
- IDLE:
  - mem_read or mem_write high goes to COMPARE next cycle. This gives one cycle for array read data to settle.
  - If both are high, the request is treated as a write.
- COMPARE, on hit:
  - Read: mem_resp = 1; go to IDLE.
  - Write: writing = 01, dirty_load = 1, dirty_in = 1, mem_resp = 1; go to IDLE.
  - hit_count increments by 1.
- COMPARE, on miss:
  - miss_count increments by 1.
  - dirty_out = 1 goes to WRITEBACK; dirty_out = 0 goes to FILL.
- WRITEBACK:
  - pmem_write = 1 held until pmem_resp. The datapath supplies the victim address {old tag, index, offset} while dirty_out = 1.
  - On the pmem_resp cycle: dirty_load = 1, dirty_in = 0, wb_count increments by 1; go to FILL.
  - Clearing dirty switches pmem_address to the request address.
- FILL:
  - pmem_read = 1 held until pmem_resp; writing = 10 while waiting, so the line is never corrupted.
  - On the pmem_resp cycle: writing = 00, tag_load = 1, valid_load = 1, dirty_load = 1, dirty_in = 0; go to RECHECK.
- RECHECK:
  - Same as the COMPARE hit path: read gives mem_resp; write does the byte-enabled merge plus sets dirty, with mem_resp.
  - hit_count is not incremented.
  - If hit = 0 here (protocol error), go back to FILL.
- Latencies:
  - Read hit: mem_resp 2 cycles after request assertion.
  - Clean miss: 3 cycles + fill latency.
  - Dirty miss: 3 cycles + writeback latency + fill latency.
- mem_resp is exactly one cycle wide. The controller never asserts pmem_read and pmem_write together.
- Request deasserted before mem_resp is a protocol violation. The controller finishes the current transaction and still pulses mem_resp.
- pmem_resp outside WRITEBACK/FILL is ignored.
- Counters wrap modulo 2^CNT_W; no saturation.

Test Plan:
- Reset then read 0x0000_0040 with a cold cache: miss_count = 1, pmem_read asserted for one fill, tag/valid/dirty loads and writing = 00 on the pmem_resp cycle, then mem_resp; repeat read gives mem_resp at request + 2 and hit_count = 1.
- Write 0x0000_0044 with byte_enable 0x0000_00F0 on the resident line: writing = 01, dirty_load = 1, dirty_in = 1, mem_resp in the COMPARE cycle; no pmem activity.
- Read 0x0000_1040 (same index 2, new tag) after the dirty write: pmem_write first, wb_count = 1; then dirty cleared and pmem_read; then mem_resp; pmem_read and pmem_write never high together.
- pmem_resp delayed 10 cycles in FILL: writing stays 10 and tag_load stays 0 until the resp cycle; exactly one mem_resp.
- rst_n low during WRITEBACK: pmem_write = 0, state IDLE and all counters 0 on the next cycle; a following read miss proceeds normally.
- mem_read and mem_write both high on a hit: behaves as a write (writing = 01, dirty set).
